// File: rtl/cell_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cell_link_pkg
// Description : Shared types and defaults for the cell-link packet router.
// Revision    : 1.0 - initial release
// ============================================================================
package cell_link_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   // bit 0 selects M00, bit 1 selects M01
   typedef logic [1:0] mask_t;

   localparam int C_DEST_BIT  = 24;
   localparam int C_BCAST_BIT = 25;

   typedef struct packed {
      logic        tlast;
      logic [31:0] tdata;
   } word_t;

   function automatic mask_t raw_mask(input logic bcast, input logic dest);
      mask_t m;
      if (bcast)
         m = 2'b11;
      else if (dest)
         m = 2'b10;
      else
         m = 2'b01;
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cell_link_fwft_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cell_link_fwft_fifo
// Description : First-word-fallthrough FIFO with count-based full/empty.
// Revision    : 1.0 - initial release
// ============================================================================
module cell_link_fwft_fifo #(
   parameter int DEPTH = 40,
   parameter int WIDTH = 33
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_wr_en,
   input  logic [WIDTH-1:0]           i_wr_data,
   input  logic                       i_rd_en,
   output logic [WIDTH-1:0]           o_rd_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == C_CNT_FULL);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign w_push  = i_wr_en & ~o_full;
   assign w_pop   = i_rd_en & ~o_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= (r_wr_ptr == C_PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
         if (w_pop)
            r_rd_ptr <= (r_rd_ptr == C_PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= i_wr_data;
   end

   // Data forced to zero while empty so the outputs read zero out of reset.
   assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/cell_link_packet_router.sv
`default_nettype none
// ============================================================================
// Module      : cell_link_packet_router
// Description : Routes TLAST-delimited packets to two FWFT output streams.
// Revision    : 1.0 - initial release
// ============================================================================
module cell_link_packet_router
   import cell_link_pkg::*;
#(
   parameter int FIFO_DEPTH = 40,
   parameter int DEST_BIT   = C_DEST_BIT,
   parameter int BCAST_BIT  = C_BCAST_BIT
) (
   input  logic        ACLK,
   input  logic        ARESETN,
   input  logic        S00_AXIS_TVALID,
   output logic        S00_AXIS_TREADY,
   input  logic [31:0] S00_AXIS_TDATA,
   input  logic        S00_AXIS_TLAST,
   output logic        M00_AXIS_TVALID,
   input  logic        M00_AXIS_TREADY,
   output logic [31:0] M00_AXIS_TDATA,
   output logic        M00_AXIS_TLAST,
   output logic        M01_AXIS_TVALID,
   input  logic        M01_AXIS_TREADY,
   output logic [31:0] M01_AXIS_TDATA,
   output logic        M01_AXIS_TLAST,
   input  logic        M00_ENABLE,
   input  logic        M01_ENABLE,
   output logic [15:0] DROP_COUNT
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   state_t      r_state;
   state_t      w_next_state;
   mask_t       r_mask;
   mask_t       w_hdr_mask;
   mask_t       w_act_mask;
   mask_t       w_wr;
   logic        w_space;
   logic        w_tready;
   logic        w_accept;
   logic        w_drop_hdr;
   logic        w_full0;
   logic        w_full1;
   logic        w_empty0;
   logic        w_empty1;
   logic [CNT_W-1:0] w_unused_count0;
   logic [CNT_W-1:0] w_unused_count1;
   logic [15:0] r_drop_count;
   word_t       w_in_word;
   word_t       w_out0;
   word_t       w_out1;

   assign w_hdr_mask = raw_mask(S00_AXIS_TDATA[BCAST_BIT], S00_AXIS_TDATA[DEST_BIT])
                     & {M01_ENABLE, M00_ENABLE};
   assign w_act_mask = (r_state == ST_IDLE) ? w_hdr_mask : r_mask;
   // A word only moves when every selected FIFO can take it, so broadcasts never split.
   assign w_space    = ~((w_act_mask[0] & w_full0) | (w_act_mask[1] & w_full1));

   assign S00_AXIS_TREADY = ARESETN & w_tready;
   assign w_accept        = S00_AXIS_TVALID & S00_AXIS_TREADY;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN)
         r_state <= ST_IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      if (w_accept) begin
         case (r_state)
            ST_IDLE: begin
               if (!S00_AXIS_TLAST)
                  w_next_state = (w_hdr_mask == '0) ? ST_DROP : ST_FWD;
            end
            ST_FWD, ST_DROP: begin
               if (S00_AXIS_TLAST)
                  w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_tready   = 1'b0;
      w_wr       = '0;
      w_drop_hdr = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_tready = w_space;
            if (S00_AXIS_TVALID && w_space) begin
               w_wr       = w_hdr_mask;
               w_drop_hdr = (w_hdr_mask == '0);
            end
         end
         ST_FWD: begin
            w_tready = w_space;
            if (S00_AXIS_TVALID && w_space)
               w_wr = r_mask;
         end
         ST_DROP: w_tready = 1'b1;
         default: w_tready = 1'b0;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_mask       <= '0;
         r_drop_count <= '0;
      end else begin
         if (r_state == ST_IDLE && w_accept)
            r_mask <= w_hdr_mask;
         if (w_drop_hdr && w_accept && r_drop_count != 16'hFFFF)
            r_drop_count <= r_drop_count + 16'd1;
      end
   end

   assign DROP_COUNT = r_drop_count;
   assign w_in_word  = '{tlast: S00_AXIS_TLAST, tdata: S00_AXIS_TDATA};

   cell_link_fwft_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(word_t))
   ) u_fifo0 (
      .clk       (ACLK),
      .rst_n     (ARESETN),
      .i_wr_en   (w_wr[0] & ARESETN),
      .i_wr_data (w_in_word),
      .i_rd_en   (M00_AXIS_TREADY),
      .o_rd_data (w_out0),
      .o_full    (w_full0),
      .o_empty   (w_empty0),
      .o_count   (w_unused_count0)
   );

   cell_link_fwft_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(word_t))
   ) u_fifo1 (
      .clk       (ACLK),
      .rst_n     (ARESETN),
      .i_wr_en   (w_wr[1] & ARESETN),
      .i_wr_data (w_in_word),
      .i_rd_en   (M01_AXIS_TREADY),
      .o_rd_data (w_out1),
      .o_full    (w_full1),
      .o_empty   (w_empty1),
      .o_count   (w_unused_count1)
   );

   assign M00_AXIS_TVALID = ~w_empty0;
   assign M00_AXIS_TDATA  = w_out0.tdata;
   assign M00_AXIS_TLAST  = w_out0.tlast;
   assign M01_AXIS_TVALID = ~w_empty1;
   assign M01_AXIS_TDATA  = w_out1.tdata;
   assign M01_AXIS_TLAST  = w_out1.tlast;

endmodule
`default_nettype wire

// File: tb/tb_cell_link_packet_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_cell_link_packet_router
// Description : Self-checking bench for the cell-link packet router.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cell_link_packet_router;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic        S00_AXIS_TVALID = 1'b0;
   logic        S00_AXIS_TREADY;
   logic [31:0] S00_AXIS_TDATA = '0;
   logic        S00_AXIS_TLAST = 1'b0;
   logic        M00_AXIS_TVALID;
   logic        M00_AXIS_TREADY = 1'b1;
   logic [31:0] M00_AXIS_TDATA;
   logic        M00_AXIS_TLAST;
   logic        M01_AXIS_TVALID;
   logic        M01_AXIS_TREADY = 1'b1;
   logic [31:0] M01_AXIS_TDATA;
   logic        M01_AXIS_TLAST;
   logic        M00_ENABLE = 1'b1;
   logic        M01_ENABLE = 1'b1;
   logic [15:0] DROP_COUNT;

   always #5 ACLK = ~ACLK;

   cell_link_packet_router dut (
      .ACLK            (ACLK),
      .ARESETN         (ARESETN),
      .S00_AXIS_TVALID (S00_AXIS_TVALID),
      .S00_AXIS_TREADY (S00_AXIS_TREADY),
      .S00_AXIS_TDATA  (S00_AXIS_TDATA),
      .S00_AXIS_TLAST  (S00_AXIS_TLAST),
      .M00_AXIS_TVALID (M00_AXIS_TVALID),
      .M00_AXIS_TREADY (M00_AXIS_TREADY),
      .M00_AXIS_TDATA  (M00_AXIS_TDATA),
      .M00_AXIS_TLAST  (M00_AXIS_TLAST),
      .M01_AXIS_TVALID (M01_AXIS_TVALID),
      .M01_AXIS_TREADY (M01_AXIS_TREADY),
      .M01_AXIS_TDATA  (M01_AXIS_TDATA),
      .M01_AXIS_TLAST  (M01_AXIS_TLAST),
      .M00_ENABLE      (M00_ENABLE),
      .M01_ENABLE      (M01_ENABLE),
      .DROP_COUNT      (DROP_COUNT)
   );

   // Observed output words, recorded on the negedge before the transfer edge.
   logic [32:0] q_out0[$];
   logic [32:0] q_out1[$];
   always @(negedge ACLK) begin
      if (M00_AXIS_TVALID && M00_AXIS_TREADY) q_out0.push_back({M00_AXIS_TLAST, M00_AXIS_TDATA});
      if (M01_AXIS_TVALID && M01_AXIS_TREADY) q_out1.push_back({M01_AXIS_TLAST, M01_AXIS_TDATA});
   end

   logic [32:0] exp0[$];
   logic [32:0] exp1[$];
   int  rd0 = 0, rd1 = 0;
   int  n_checks = 0, n_pass = 0;
   int  exp_drops = 0;
   bit  in_pkt = 0, cur_to0 = 0, cur_to1 = 0;
   bit  rand_rdy0 = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference routing: destinations decided once per packet from its header.
   task automatic model_accept(input logic [31:0] d, input logic last);
      if (!in_pkt) begin
         cur_to0 = (d[25] || !d[24]) && M00_ENABLE;
         cur_to1 = (d[25] ||  d[24]) && M01_ENABLE;
         if (!cur_to0 && !cur_to1) exp_drops++;
      end
      if (cur_to0) exp0.push_back({last, d});
      if (cur_to1) exp1.push_back({last, d});
      in_pkt = !last;
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
      if (rand_rdy0) M00_AXIS_TREADY = 1'($urandom_range(0, 1));
   endtask

   task automatic send_word(input logic [31:0] d, input logic last, input int budget, output bit ok);
      S00_AXIS_TVALID = 1'b1;
      S00_AXIS_TDATA  = d;
      S00_AXIS_TLAST  = last;
      ok = 0;
      for (int c = 0; c < budget && !ok; c++) begin
         @(negedge ACLK);
         if (S00_AXIS_TREADY) begin
            ok = 1;
            model_accept(d, last);
         end
         step();
      end
      S00_AXIS_TVALID = 1'b0;
   endtask

   task automatic send_packet(input logic [31:0] hdr, input int nwords, input bit kill_en0, input string tag);
      bit ok;
      bit all_ok;
      all_ok = 1;
      for (int i = 0; i < nwords; i++) begin
         send_word((i == 0) ? hdr : $urandom, (i == nwords - 1), 200, ok);
         all_ok &= ok;
         if (i == 0 && kill_en0) M00_ENABLE = 1'b0;
      end
      chk({tag, "_accepted"}, 64'(all_ok), 64'd1);
   endtask

   task automatic drain_check(input string tag);
      for (int n = 0; n < 3000; n++) begin
         if ((q_out0.size() - rd0) >= exp0.size() && (q_out1.size() - rd1) >= exp1.size()) break;
         step();
      end
      repeat (4) step();
      chk({tag, "_count_m00"}, 64'(q_out0.size() - rd0), 64'(exp0.size()));
      chk({tag, "_count_m01"}, 64'(q_out1.size() - rd1), 64'(exp1.size()));
      for (int i = 0; i < exp0.size(); i++)
         chk({tag, "_m00_word"}, (rd0 + i < q_out0.size()) ? q_out0[rd0 + i] : {33{1'bx}}, exp0[i]);
      for (int i = 0; i < exp1.size(); i++)
         chk({tag, "_m01_word"}, (rd1 + i < q_out1.size()) ? q_out1[rd1 + i] : {33{1'bx}}, exp1[i]);
      rd0 = q_out0.size();
      rd1 = q_out1.size();
      exp0.delete();
      exp1.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit ok;
      int idx;
      logic [31:0] hdr;

      // Reset state
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      chk("rst_tready", 64'(S00_AXIS_TREADY), 64'd0);
      chk("rst_m00_tvalid", 64'(M00_AXIS_TVALID), 64'd0);
      chk("rst_m01_tvalid", 64'(M01_AXIS_TVALID), 64'd0);
      chk("rst_m00_tdata", 64'(M00_AXIS_TDATA), 64'd0);
      chk("rst_m01_tlast", 64'(M01_AXIS_TLAST), 64'd0);
      chk("rst_drop_count", 64'(DROP_COUNT), 64'd0);
      @(posedge ACLK);
      #1 ARESETN = 1'b1;
      step();

      // Unicast to M00
      send_packet(32'h0000_0001, 5, 0, "unicast");
      drain_check("unicast");

      // Broadcast with M01 stalled
      M01_AXIS_TREADY = 1'b0;
      idx = 0;
      ok  = 1;
      while (idx < 45 && ok) begin
         hdr = 32'h0200_0000 | ($urandom & 32'h01FF_FFFF);
         send_word(hdr, 1'b1, 5, ok);
         if (ok) idx++;
      end
      chk("bcast_stall_index", 64'(idx), 64'd40);
      @(negedge ACLK);
      chk("bcast_stall_tready", 64'(S00_AXIS_TREADY), 64'd0);
      chk("bcast_m00_held", 64'(q_out0.size() - rd0), 64'd40);
      step();
      M01_AXIS_TREADY = 1'b1;
      while (idx < 45) begin
         send_word(hdr, 1'b1, 200, ok);
         chk("bcast_resume_accept", 64'(ok), 64'd1);
         idx++;
         hdr = 32'h0200_0000 | ($urandom & 32'h01FF_FFFF);
      end
      drain_check("bcast");

      // Disabled destination
      M01_ENABLE = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send_word((i == 0) ? (32'h0100_0000 | ($urandom & 32'h00FF_FFFF)) : $urandom,
                   (i == 2), 1, ok);
         chk("disabled_tready", 64'(ok), 64'd1);
      end
      @(negedge ACLK);
      chk("disabled_drop_count", 64'(DROP_COUNT), 64'd1);
      step();
      send_packet(32'h0000_00A5, 3, 0, "after_drop");
      drain_check("disabled");
      M01_ENABLE = 1'b1;

      // Enable toggled mid-packet
      send_packet(32'h00C0_FFEE, 5, 1, "toggle");
      send_packet(32'h0000_0042, 2, 0, "toggle_next");
      @(negedge ACLK);
      chk("toggle_drop_count", 64'(DROP_COUNT), 64'(exp_drops));
      step();
      drain_check("toggle");
      M00_ENABLE = 1'b1;

      // Asynchronous reset mid-packet
      M00_AXIS_TREADY = 1'b0;
      send_word(32'h0000_1234, 1'b0, 200, ok);
      send_word($urandom, 1'b0, 200, ok);
      #2;
      chk("prereset_m00_tvalid", 64'(M00_AXIS_TVALID), 64'd1);
      ARESETN = 1'b0;
      #1;
      chk("areset_m00_tvalid", 64'(M00_AXIS_TVALID), 64'd0);
      chk("areset_m01_tvalid", 64'(M01_AXIS_TVALID), 64'd0);
      chk("areset_drop_count", 64'(DROP_COUNT), 64'd0);
      chk("areset_tready", 64'(S00_AXIS_TREADY), 64'd0);
      exp0.delete();
      exp1.delete();
      exp_drops = 0;
      in_pkt = 0;
      repeat (3) @(posedge ACLK);
      #1 ARESETN = 1'b1;
      M00_AXIS_TREADY = 1'b1;
      step();
      rd0 = q_out0.size();
      rd1 = q_out1.size();
      send_packet(32'h0000_5678, 3, 0, "postreset_uni");
      send_packet(32'h0300_0001, 2, 0, "postreset_bc");
      drain_check("postreset");

      // Pointer wrap-around with random backpressure on M00
      rand_rdy0 = 1;
      for (int i = 0; i < 100; i++) begin
         send_word($urandom & 32'h00FF_FFFF, 1'b1, 400, ok);
         if (!ok) chk("wrap_accept", 64'(ok), 64'd1);
      end
      drain_check("wrap");
      rand_rdy0 = 0;
      M00_AXIS_TREADY = 1'b1;

      @(negedge ACLK);
      chk("final_drop_count", 64'(DROP_COUNT), 64'(exp_drops));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cell_link_packet_router.md
# cell_link_packet_router

Splits one TLAST-delimited 32-bit cell-link AXI-Stream into two output streams, routing each packet by destination/broadcast bits in its header word. It is the fan-out counterpart of the two-into-one forward merge: it sits after the cell-link receive path and feeds the two per-link transmit paths. Each output has its own first-word-fallthrough FIFO. Packets addressed to a disabled output are discarded and counted.

## Interface
- FIFO_DEPTH, 40: words per output FIFO (8 packets of 5 words).
- DEST_BIT, 24: header bit selecting output (0 → M00, 1 → M01).
- BCAST_BIT, 25: header bit; 1 routes the packet to both outputs.
- ACLK  in  1  single clock for all logic.
- ARESETN  in  1  reset, asynchronous, active-low.
- S00_AXIS_TVALID / S00_AXIS_TREADY  in / out  1  input handshake.
- S00_AXIS_TDATA  in  32  input data; the first word of a packet is the header.
- S00_AXIS_TLAST  in  1  marks the last word of a packet.
- M00_AXIS_TVALID / M00_AXIS_TREADY  out / in  1  output 0 handshake.
- M00_AXIS_TDATA / M00_AXIS_TLAST  out  32 / 1  output 0 data.
- M01_AXIS_* : same as M00, for output 1.
- M00_ENABLE, M01_ENABLE  in  1  per-output enable, sampled only at header acceptance.
- DROP_COUNT  out  16  count of dropped packets, saturating.

## Operation
- States: IDLE (awaiting header), FWD (forwarding body to latched mask), DROP (discarding body).
- Mask computation in IDLE, combinational from the header TDATA:
  - If BCAST_BIT=1, raw mask = 2'b11.
  - Otherwise raw mask = one-hot of DEST_BIT.
  - mask = raw & {M01_ENABLE, M00_ENABLE}.
- S00_AXIS_TREADY:
  - IDLE: 1 if mask==0; otherwise 1 only if every FIFO selected in mask is not full.
  - FWD: same rule, using the latched mask.
  - DROP: 1.
  - TREADY may depend combinationally on TDATA in IDLE.
- Header accept:
  - Nonzero mask: header is written to each selected FIFO and mask is latched. Next state is FWD, or IDLE if TLAST is set.
  - Zero mask: header is discarded and DROP_COUNT increments (saturates at 0xFFFF). Next state is DROP, or IDLE if TLAST is set.
- FWD: each accepted word is written to all latched FIFOs in the same cycle. TLAST returns to IDLE.
- DROP: words are accepted and discarded. TLAST returns to IDLE.
- Broadcast words never split: a word is accepted only when both FIFOs have space.
- Enable changes mid-packet are ignored until the next header.
- Output ordering: each output preserves input order. No interleaving within an output.

## Timing
- Reset values:
  - S00_AXIS_TREADY=0 while ARESETN low.
  - M0x_AXIS_TVALID=0, TDATA=0, TLAST=0.
  - DROP_COUNT=0, state IDLE, FIFOs empty.
- Reset mid-packet: all FIFO contents flushed; the partial packet is lost with no TLAST emitted.
- Latency: a word accepted at edge N is presented on M0x (TVALID=1) after edge N (FWFT); minimum 1 cycle.
- FIFO full: when count==FIFO_DEPTH, writes are blocked via TREADY. A read in the same cycle frees space only from the next cycle (no pass-through when full).
- FIFO empty with simultaneous write: TVALID rises the cycle after the write; no combinational bypass.
- Simultaneous read and write when neither full nor empty: count unchanged.
- Pointers wrap from FIFO_DEPTH-1 to 0. Full/empty are distinguished by a count register of width $clog2(FIFO_DEPTH+1).
- M0x_AXIS_TDATA/TLAST are stable while TVALID=1 and TREADY=0.

## Structure
- Package cell_link_pkg holds:
  - state enum {IDLE, FWD, DROP};
  - 2-bit mask type;
  - DEST_BIT/BCAST_BIT defaults;
  - 33-bit {tlast,tdata} word type.
- Sub-module cell_link_fwft_fifo (parameters DEPTH and WIDTH=33; async active-low reset; full, empty, count) is instantiated twice.
- The router top level holds the FSM, mask latch, TREADY logic and drop counter.

## Test plan
- Unicast to M00: header 0x0000_0001 then 4 words, last with TLAST. Required: identical 5 words on M00, TLAST on word 5, M01 idle.
- Broadcast with M01 stalled: header bit 25 set, 45 single-word packets, M01_AXIS_TREADY=0. Required: S00_AXIS_TREADY drops after 40 words; M00 also holds at 40 words; no word duplicated or lost after releasing M01.
- Disabled destination: M01_ENABLE=0, send a 3-word packet to M01 (header bit 24 set). Required: TREADY stays 1, nothing appears on M01, DROP_COUNT=1, and the next M00 packet routes normally.
- Enable toggled mid-packet: deassert M00_ENABLE after the header of a 5-word M00 packet. Required: all 5 words delivered; the next M00 header is dropped.
- Async reset mid-packet: assert ARESETN=0 after word 2 of a packet, hold 3 cycles. Required: all TVALID=0 and DROP_COUNT=0 immediately; the next packet after reset routes correctly.
- Wrap-around: stream 100 single-word packets to M00 with random M00_AXIS_TREADY. Required: output sequence equals input sequence.
